// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, one idle-high cycle between frames.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit after data bit 7.
module uart_tx #(
   parameter int CLKS_PER_BIT = 521
) (
   input  logic       tx_clk,
   input  logic       tx_rst,
   input  logic       tx_start,
   input  logic [7:0] tx_in,
   output logic       tx_out,
   output logic       tx_busy,
   output logic       tx_done
);

   // Handshake: tx_start is the valid, !tx_busy is the ready; a byte is taken
   // only on a cycle where both are high, and nothing else is ever sampled.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA_BURST,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  bit_idx, bit_n;
   logic [7:0]  shreg, shreg_n;
   logic        out_n, busy_n, done_n;
   logic        bit_end;

   assign bit_end = (cnt == LAST);

   always_ff @(posedge tx_clk) begin
      if (tx_rst) begin
         state   <= IDLE;
         cnt     <= 16'd0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
         tx_out  <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shreg   <= shreg_n;
         tx_out  <= out_n;
         tx_busy <= busy_n;
         tx_done <= done_n;
      end
   end

   // Outputs are computed one cycle ahead so they leave the block registered.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_idx;
      shreg_n = shreg;
      out_n   = tx_out;
      busy_n  = tx_busy;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            out_n  = 1'b1;
            busy_n = 1'b0;
            if (tx_start) begin
               shreg_n = tx_in;
               state_n = START;
               cnt_n   = 16'd0;
               bit_n   = 3'd0;
               out_n   = 1'b0;
               busy_n  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_n   = 16'd0;
               state_n = DATA_BURST;
               out_n   = shreg[0];
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         DATA_BURST: begin
            if (bit_end) begin
               cnt_n = 16'd0;
               if (bit_idx == 3'd7) begin
                  bit_n = 3'd0;
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
                  out_n   = ^shreg;
`else
                  state_n = STOP;
                  out_n   = 1'b1;
`endif
               end else begin
                  bit_n = bit_idx + 3'd1;
                  out_n = shreg[bit_idx + 3'd1];
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               cnt_n   = 16'd0;
               state_n = STOP;
               out_n   = 1'b1;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               cnt_n   = 16'd0;
               state_n = IDLE;
               out_n   = 1'b1;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 16'd0;
            bit_n   = 3'd0;
            out_n   = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a short-period instance (4 clocks/bit) for the
// functional scenarios and a 521 clocks/bit instance for the full-size period.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
   localparam bit PAR_EN     = 1'b1;
`else
   localparam int FRAME_BITS = 10;
   localparam bit PAR_EN     = 1'b0;
`endif
   localparam int NS = 4;
   localparam int NL = 521;

   logic       tx_clk = 1'b0;
   logic       tx_rst;
   logic       tx_start, tx_start_l;
   logic [7:0] tx_in, tx_in_l;
   logic       tx_out, tx_busy, tx_done;
   logic       tx_out_l, tx_busy_l, tx_done_l;

   int checks = 0;
   int errors = 0;

   always #5 tx_clk = ~tx_clk;

   uart_tx #(.CLKS_PER_BIT(NS)) dut_s (
      .tx_clk(tx_clk), .tx_rst(tx_rst), .tx_start(tx_start), .tx_in(tx_in),
      .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   uart_tx #(.CLKS_PER_BIT(NL)) dut_l (
      .tx_clk(tx_clk), .tx_rst(tx_rst), .tx_start(tx_start_l), .tx_in(tx_in_l),
      .tx_out(tx_out_l), .tx_busy(tx_busy_l), .tx_done(tx_done_l)
   );

   // Expected line state in cycle c of a frame accepted in cycle 0.
   function automatic logic exp_out(input logic [7:0] b, input int c, input int n);
      int k;
      if (c < 1) return 1'b1;
      k = (c - 1) / n;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (PAR_EN && k == 9) return ^b;
      return 1'b1;
   endfunction

   function automatic logic exp_busy(input int c, input int n);
      return (c >= 1 && c <= FRAME_BITS * n);
   endfunction

   function automatic logic exp_done(input int c, input int n);
      return (c == FRAME_BITS * n + 1);
   endfunction

   task automatic tick();
      @(posedge tx_clk);
      #1;
   endtask

   task automatic test_reset();
      tx_rst = 1'b1; tx_start = 1'b0; tx_in = 8'h00; tx_start_l = 1'b0; tx_in_l = 8'h00;
      tick(); tick();
      checks++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_short: out=%b busy=%b done=%b, required 1 0 0", tx_out, tx_busy, tx_done);
      end
      checks++;
      if (tx_out_l !== 1'b1 || tx_busy_l !== 1'b0 || tx_done_l !== 1'b0) begin
         errors++;
         $display("FAIL reset_long: out=%b busy=%b done=%b, required 1 0 0", tx_out_l, tx_busy_l, tx_done_l);
      end
      tx_rst = 1'b0;
      tick();
   endtask

   task automatic test_frame(input logic [7:0] b);
      tx_in = b; tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      for (int c = 1; c <= FRAME_BITS * NS + 5; c++) begin
         checks++;
         if (tx_out !== exp_out(b, c, NS) || tx_busy !== exp_busy(c, NS) || tx_done !== exp_done(c, NS)) begin
            errors++;
            $display("FAIL frame_%h cycle %0d: out=%b busy=%b done=%b, required %b %b %b", b, c,
                     tx_out, tx_busy, tx_done, exp_out(b, c, NS), exp_busy(c, NS), exp_done(c, NS));
         end
         tick();
      end
   endtask

   task automatic test_ignore_busy();
      tx_in = 8'hA5; tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      for (int c = 1; c <= FRAME_BITS * NS + 20; c++) begin
         checks++;
         if (tx_out !== exp_out(8'hA5, c, NS) || tx_busy !== exp_busy(c, NS) || tx_done !== exp_done(c, NS)) begin
            errors++;
            $display("FAIL ignore_busy cycle %0d: out=%b busy=%b done=%b, required %b %b %b", c,
                     tx_out, tx_busy, tx_done, exp_out(8'hA5, c, NS), exp_busy(c, NS), exp_done(c, NS));
         end
         if (c == 10) begin tx_start = 1'b1; tx_in = 8'hFF; end
         if (c == 11) tx_start = 1'b0;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int t2;
      logic eo, eb, ed;
      t2 = FRAME_BITS * NS + 1;
      tx_in = 8'h00; tx_start = 1'b1;
      tick();
      tx_in = 8'h55;
      for (int c = 1; c <= 2 * t2 + 5; c++) begin
         eo = (c <= t2) ? exp_out(8'h00, c, NS) : exp_out(8'h55, c - t2, NS);
         eb = exp_busy(c, NS) | exp_busy(c - t2, NS);
         ed = exp_done(c, NS) | exp_done(c - t2, NS);
         checks++;
         if (tx_out !== eo || tx_busy !== eb || tx_done !== ed) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: out=%b busy=%b done=%b, required %b %b %b", c,
                     tx_out, tx_busy, tx_done, eo, eb, ed);
         end
         if (c == t2 + 1) tx_start = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset_mid_frame();
      tx_in = 8'hA5; tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         checks++;
         if (tx_out !== exp_out(8'hA5, c, NS) || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame cycle %0d: out=%b busy=%b, required %b 1", c, tx_out, tx_busy,
                     exp_out(8'hA5, c, NS));
         end
         if (c < 15) tick();
      end
      tx_rst = 1'b1; tx_start = 1'b1;
      tick();
      checks++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort cycle 16: out=%b busy=%b done=%b, required 1 0 0", tx_out, tx_busy, tx_done);
      end
      tick();
      tx_rst = 1'b0; tx_start = 1'b0;
      for (int c = 0; c < 60; c++) begin
         checks++;
         if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL after_abort cycle %0d: out=%b busy=%b done=%b, required 1 0 0", c,
                     tx_out, tx_busy, tx_done);
         end
         tick();
      end
   endtask

   task automatic test_reset_release();
      tx_rst = 1'b1; tx_start = 1'b1; tx_in = 8'h07;
      tick();
      checks++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL start_during_reset: out=%b busy=%b, required 1 0", tx_out, tx_busy);
      end
      tx_rst = 1'b0;
      tick();
      tx_start = 1'b0;
      for (int c = 1; c <= FRAME_BITS * NS + 3; c++) begin
         checks++;
         if (tx_out !== exp_out(8'h07, c, NS) || tx_busy !== exp_busy(c, NS) || tx_done !== exp_done(c, NS)) begin
            errors++;
            $display("FAIL release_frame cycle %0d: out=%b busy=%b done=%b, required %b %b %b", c,
                     tx_out, tx_busy, tx_done, exp_out(8'h07, c, NS), exp_busy(c, NS), exp_done(c, NS));
         end
         tick();
      end
   endtask

   task automatic test_long_period();
      tx_in_l = 8'h3C; tx_start_l = 1'b1;
      tick();
      tx_start_l = 1'b0;
      for (int c = 1; c <= FRAME_BITS * NL + 3; c++) begin
         checks++;
         if (tx_out_l !== exp_out(8'h3C, c, NL) || tx_busy_l !== exp_busy(c, NL) ||
             tx_done_l !== exp_done(c, NL)) begin
            errors++;
            $display("FAIL long_period cycle %0d: out=%b busy=%b done=%b, required %b %b %b", c,
                     tx_out_l, tx_busy_l, tx_done_l, exp_out(8'h3C, c, NL), exp_busy(c, NL), exp_done(c, NL));
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_frame(8'hA5);
      test_frame(8'h07);
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid_frame();
      test_reset_release();
      test_long_period();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
